// File: rtl/gauss_filter_3x3.sv
// 3x3 Gaussian smoothing stage for RGB video ([1 2 1;2 4 2;1 2 1]/16 per channel).
// Fixed 4-cycle latency for syncs, data enable and pixel, in both filter and bypass modes.
module gauss_filter_3x3 #(
    parameter int unsigned COLOR_DEPTH = 8,
    parameter int unsigned H_ACT       = 1920,
    parameter int unsigned X_BITS      = 12,
    parameter int unsigned Y_BITS      = 12,
    parameter int unsigned VS_POL      = 1
) (
    input  logic                     pix_clk,
    input  logic                     rstn,
    input  logic                     filter_en,
    input  logic                     vs_in,
    input  logic                     hs_in,
    input  logic                     de_in,
    input  logic [3*COLOR_DEPTH-1:0] pixel_data_in,
    output logic                     vs_out,
    output logic                     hs_out,
    output logic                     de_out,
    output logic [3*COLOR_DEPTH-1:0] pixel_data_out
);

    localparam int unsigned PIX_W  = 3 * COLOR_DEPTH;
    localparam int unsigned SUM_W  = COLOR_DEPTH + 4;
    localparam int unsigned ADDR_W = (H_ACT > 1) ? $clog2(H_ACT) : 1;
    localparam logic [X_BITS-1:0] COL_MAX = X_BITS'(H_ACT - 1);
    localparam logic [Y_BITS-1:0] ROW_MAX = '1;
    localparam logic              VS_ACT  = (VS_POL != 0);

    logic [X_BITS-1:0] col_q;
    logic [Y_BITS-1:0] row_q;
    logic              vs_prev_q;
    logic              de_prev_q;
    logic              vs_rise;
    logic              de_fall;
    logic [Y_BITS-1:0] row_eff;
    logic              border;
    logic [ADDR_W-1:0] addr;

    assign vs_rise = (vs_in == VS_ACT) && (vs_prev_q != VS_ACT);
    assign de_fall = de_prev_q && !de_in;
    // A pixel arriving together with the vs edge already belongs to row 0.
    assign row_eff = vs_rise ? '0 : row_q;
    assign border  = (col_q < X_BITS'(2)) || (row_eff < Y_BITS'(2));
    assign addr    = col_q[ADDR_W-1:0];

    always_ff @(posedge pix_clk) begin
        if (!rstn) begin
            col_q     <= '0;
            row_q     <= '0;
            vs_prev_q <= !VS_ACT;
            de_prev_q <= 1'b0;
        end else begin
            vs_prev_q <= vs_in;
            de_prev_q <= de_in;
            if (de_in) begin
                if (col_q != COL_MAX) col_q <= col_q + X_BITS'(1);
            end else begin
                col_q <= '0;
            end
            if (vs_rise) begin
                row_q <= '0;
            end else if (de_fall && (row_q != ROW_MAX)) begin
                row_q <= row_q + Y_BITS'(1);
            end
        end
    end

    // Line buffers: LB1 holds row y-1, LB2 row y-2; no reset on the RAM itself.
    logic [PIX_W-1:0] lb1 [H_ACT];
    logic [PIX_W-1:0] lb2 [H_ACT];

    always_ff @(posedge pix_clk) begin
        if (de_in) begin
            lb1[addr] <= pixel_data_in;
            lb2[addr] <= lb1[addr];
        end
    end

    // Stage 1: registered line-buffer reads plus the incoming pixel.
    logic [PIX_W-1:0] lb1_rd_q, lb2_rd_q, pix1_q, pix2_q, pix3_q;
    logic [2:0]       ctl1_q, ctl2_q, ctl3_q;   // {vs, hs, de}
    logic             byp1_q, byp2_q, byp3_q;
    logic [PIX_W-1:0] win_q [3][3];             // [row y-2..y][col x..x-2]
    logic [SUM_W-1:0] sum_d [3];
    logic [SUM_W-1:0] sum_q [3];
    logic [SUM_W-1:0] rnd;
    logic [PIX_W-1:0] flt_d;

    always_ff @(posedge pix_clk) begin
        if (!rstn) begin
            lb1_rd_q <= '0;
            lb2_rd_q <= '0;
            pix1_q   <= '0;
            ctl1_q   <= '0;
            byp1_q   <= 1'b0;
        end else begin
            lb1_rd_q <= lb1[addr];
            lb2_rd_q <= lb2[addr];
            pix1_q   <= pixel_data_in;
            ctl1_q   <= {vs_in, hs_in, de_in};
            byp1_q   <= !filter_en || border;
        end
    end

    // Stage 2: window shift; column history is dropped between lines.
    always_ff @(posedge pix_clk) begin
        if (!rstn) begin
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
            end
            pix2_q <= '0;
            ctl2_q <= '0;
            byp2_q <= 1'b0;
        end else begin
            if (ctl1_q[0]) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][2] <= win_q[r][1];
                    win_q[r][1] <= win_q[r][0];
                end
                win_q[0][0] <= lb2_rd_q;
                win_q[1][0] <= lb1_rd_q;
                win_q[2][0] <= pix1_q;
            end else begin
                for (int r = 0; r < 3; r++) begin
                    for (int c = 0; c < 3; c++) win_q[r][c] <= '0;
                end
            end
            pix2_q <= pix1_q;
            ctl2_q <= ctl1_q;
            byp2_q <= byp1_q;
        end
    end

    always_comb begin
        int unsigned sh;
        sh = 0;
        for (int ch = 0; ch < 3; ch++) begin
            sum_d[ch] = '0;
            for (int r = 0; r < 3; r++) begin
                for (int c = 0; c < 3; c++) begin
                    sh = ((r == 1) ? 1 : 0) + ((c == 1) ? 1 : 0);
                    sum_d[ch] = sum_d[ch]
                              + (SUM_W'(win_q[r][c][ch*COLOR_DEPTH +: COLOR_DEPTH]) << sh);
                end
            end
        end
    end

    // Stage 3: per-channel weighted sums.
    always_ff @(posedge pix_clk) begin
        if (!rstn) begin
            for (int ch = 0; ch < 3; ch++) sum_q[ch] <= '0;
            pix3_q <= '0;
            ctl3_q <= '0;
            byp3_q <= 1'b0;
        end else begin
            for (int ch = 0; ch < 3; ch++) sum_q[ch] <= sum_d[ch];
            pix3_q <= pix2_q;
            ctl3_q <= ctl2_q;
            byp3_q <= byp2_q;
        end
    end

    // Round half up; the sum never exceeds 16*max so the result always fits.
    always_comb begin
        rnd   = '0;
        flt_d = '0;
        for (int ch = 0; ch < 3; ch++) begin
            rnd = (sum_q[ch] + SUM_W'(8)) >> 4;
            flt_d[ch*COLOR_DEPTH +: COLOR_DEPTH] = rnd[COLOR_DEPTH-1:0];
        end
    end

    // Stage 4: registered outputs.
    always_ff @(posedge pix_clk) begin
        if (!rstn) begin
            vs_out         <= 1'b0;
            hs_out         <= 1'b0;
            de_out         <= 1'b0;
            pixel_data_out <= '0;
        end else begin
            vs_out <= ctl3_q[2];
            hs_out <= ctl3_q[1];
            de_out <= ctl3_q[0];
            if (!ctl3_q[0]) begin
                pixel_data_out <= '0;
            end else if (byp3_q) begin
                pixel_data_out <= pix3_q;
            end else begin
                pixel_data_out <= flt_d;
            end
        end
    end

endmodule

// File: tb/tb_gauss_filter_3x3.sv
// Bench for gauss_filter_3x3 on a reduced raster: frame-level model of the
// Gaussian window plus a per-cycle stream compare and literal pixel pins.
module tb_gauss_filter_3x3;

    localparam int unsigned H_ACT   = 16;
    localparam int unsigned V_ACT   = 14;
    localparam int unsigned H_TOTAL = 24;
    localparam int unsigned V_TOTAL = 20;
    localparam int unsigned V_START = 4;
    localparam int unsigned MAXC    = 16384;

    logic        pix_clk = 1'b0;
    logic        rstn = 1'b0, filter_en = 1'b0;
    logic        vs_in = 1'b0, hs_in = 1'b0, de_in = 1'b0;
    logic [23:0] pixel_data_in = '0;
    logic        vs_out, hs_out, de_out;
    logic [23:0] pixel_data_out;

    gauss_filter_3x3 #(.H_ACT(H_ACT)) u_dut (
        .pix_clk       (pix_clk),
        .rstn          (rstn),
        .filter_en     (filter_en),
        .vs_in         (vs_in),
        .hs_in         (hs_in),
        .de_in         (de_in),
        .pixel_data_in (pixel_data_in),
        .vs_out        (vs_out),
        .hs_out        (hs_out),
        .de_out        (de_out),
        .pixel_data_out(pixel_data_out)
    );

    always #5 pix_clk = ~pix_clk;

    typedef struct {
        bit          valid;
        bit          rstn;
        bit          vs;
        bit          hs;
        bit          de;
        logic [23:0] pix;
        int          x;
        int          y;
    } ent_t;

    ent_t        hist [MAXC];
    logic [23:0] img [V_ACT][H_ACT];
    logic [23:0] out_img [V_ACT][H_ACT];
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    int          de_out_cnt = 0;

    always @(posedge pix_clk) cyc <= cyc + 1;

    // Expected output for input (x,y): border/bypass passes the pixel, else 3x3 weighted mean.
    function automatic logic [23:0] model_pix(int x, int y, bit en);
        logic [23:0] r;
        int          s;
        r = '0;
        if (!en || x < 2 || y < 2) return img[y][x];
        for (int ch = 0; ch < 3; ch++) begin
            s = 0;
            for (int dy = 0; dy < 3; dy++) begin
                for (int dx = 0; dx < 3; dx++) begin
                    s += ((dy == 1) ? 2 : 1) * ((dx == 1) ? 2 : 1)
                       * int'(img[y-2+dy][x-2+dx][ch*8 +: 8]);
                end
            end
            r[ch*8 +: 8] = 8'((s + 8) / 16);
        end
        return r;
    endfunction

    function automatic logic [23:0] gen(int mode, int x, int y);
        case (mode)
            0:       return 24'h808080;
            1:       return (x == 10 && y == 10) ? 24'hFFFFFF : 24'h000000;
            2:       return {8'(x), 8'(y), 8'h55};
            3:       return 24'($urandom);
            default: return 24'hFFFFFF;
        endcase
    endfunction

    task automatic drive(bit r, bit v, bit h, bit d, logic [23:0] p, bit en, int x, int y,
                         logic [23:0] ep);
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, MAXC);
            $fatal(1);
        end
        rstn          = r;
        vs_in         = v;
        hs_in         = h;
        de_in         = d;
        pixel_data_in = p;
        filter_en     = en;
        hist[cyc].valid = 1'b1;
        hist[cyc].rstn  = r;
        hist[cyc].vs    = v;
        hist[cyc].hs    = h;
        hist[cyc].de    = d;
        hist[cyc].pix   = d ? ep : 24'h0;
        hist[cyc].x     = x;
        hist[cyc].y     = y;
        @(posedge pix_clk);
        #1;
    endtask

    // enmode: 0/1 constant filter_en, 2 random per pixel. rst_line < 0 means no reset.
    task automatic run_frame(int mode, int enmode, int rst_line);
        bit          in_rst;
        bit          v, h, en;
        logic [23:0] p;
        in_rst = 1'b0;
        for (int l = 0; l < int'(V_TOTAL); l++) begin
            for (int hc = 0; hc < int'(H_TOTAL); hc++) begin
                if (l == rst_line && hc == int'(H_ACT) / 2) in_rst = 1'b1;
                if (in_rst) begin
                    drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, -1, -1, 24'h0);
                end else begin
                    v = (l < 2);
                    h = (hc >= int'(H_ACT) + 2) && (hc < int'(H_ACT) + 5);
                    if (l >= int'(V_START) && l < int'(V_START + V_ACT) && hc < int'(H_ACT)) begin
                        p = gen(mode, hc, l - int'(V_START));
                        img[l - int'(V_START)][hc] = p;
                        en = (enmode == 2) ? 1'($urandom) : (enmode != 0);
                        drive(1'b1, v, h, 1'b1, p, en, hc, l - int'(V_START),
                              model_pix(hc, l - int'(V_START), en));
                    end else begin
                        drive(1'b1, v, h, 1'b0, 24'($urandom), 1'b1, -1, -1, 24'h0);
                    end
                end
            end
        end
    endtask

    task automatic check(string name, logic [23:0] got, logic [23:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Stream compare: output after edge m reflects the input driven before edge m-3,
    // or zero when reset was sampled on any of the last four edges.
    int          m;
    bit          z;
    logic [2:0]  e_ctl;
    logic [23:0] e_pix;
    always @(negedge pix_clk) begin
        m = cyc;
        if (m >= 4 && m <= int'(MAXC) && hist[m-4].valid && hist[m-1].valid) begin
            z = 1'b0;
            for (int i = 1; i <= 4; i++) if (!hist[m-i].rstn) z = 1'b1;
            e_ctl = z ? 3'b000 : {hist[m-4].vs, hist[m-4].hs, hist[m-4].de};
            e_pix = z ? 24'h0 : hist[m-4].pix;
            n_chk++;
            if ($isunknown({vs_out, hs_out, de_out, pixel_data_out}) ||
                {vs_out, hs_out, de_out} !== e_ctl || pixel_data_out !== e_pix) begin
                n_fail++;
                $display("FAIL stream cyc=%0d got vs/hs/de=%b pix=%h expected vs/hs/de=%b pix=%h",
                         m, {vs_out, hs_out, de_out}, pixel_data_out, e_ctl, e_pix);
            end
            if (!z && hist[m-4].de) out_img[hist[m-4].y][hist[m-4].x] = pixel_data_out;
            if (de_out) de_out_cnt++;
        end
    end

    int nz;

    initial begin
        for (int i = 0; i < 6; i++) drive(1'b0, 1'b0, 1'b0, 1'b0, 24'h0, 1'b0, -1, -1, 24'h0);

        // Uniform grey
        run_frame(0, 1, -1);
        check("uniform_7_7", out_img[7][7], 24'h808080);
        check("uniform_0_0", out_img[0][0], 24'h808080);

        // Single white pixel at (10,10): response centred on (11,11)
        run_frame(1, 1, -1);
        check("imp_11_11", out_img[11][11], 24'h404040);
        check("imp_10_11", out_img[11][10], 24'h202020);
        check("imp_12_11", out_img[11][12], 24'h202020);
        check("imp_11_10", out_img[10][11], 24'h202020);
        check("imp_11_12", out_img[12][11], 24'h202020);
        check("imp_10_10", out_img[10][10], 24'h101010);
        check("imp_12_12", out_img[12][12], 24'h101010);
        check("imp_12_10", out_img[10][12], 24'h101010);
        nz = 0;
        for (int y = 0; y < int'(V_ACT); y++)
            for (int x = 0; x < int'(H_ACT); x++) if (out_img[y][x] != 24'h0) nz++;
        check("imp_nonzero_count", 24'(nz), 24'd9);

        // Ramp {x,y,55}: borders pass through, interior R=x-1, G=y-1
        run_frame(2, 1, -1);
        check("ramp_row0", out_img[0][5], 24'h050055);
        check("ramp_col1", out_img[5][1], 24'h010555);
        check("ramp_2_2", out_img[2][2], 24'h010155);
        check("ramp_5_7", out_img[7][5], 24'h040655);

        // Bypass on random data, then random data with per-pixel filter_en toggling
        run_frame(3, 0, -1);
        check("bypass_5_5", out_img[5][5], img[5][5]);
        run_frame(3, 2, -1);

        // White frame with reset in the middle, then ramp to show rows 0-1 bypass again
        run_frame(4, 1, int'(V_START) + 7);
        check("white_3_3", out_img[3][3], 24'hFFFFFF);
        run_frame(2, 1, -1);
        check("post_rst_row1", out_img[1][5], 24'h050155);
        check("post_rst_row2", out_img[2][5], 24'h040155);

        // Two back-to-back frames: count of de_out cycles
        de_out_cnt = 0;
        run_frame(3, 1, -1);
        run_frame(3, 1, -1);
        check("de_out_count", 24'(de_out_cnt), 24'(2 * H_ACT * V_ACT));

        for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, 1'b0, 1'b0, 24'h0, 1'b1, -1, -1, 24'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
